// File: rtl/riscv_mem_map_pkg.sv
// Memory-map constants shared by the load and store paths.
//   - region nibbles decoded from addr[31:28]
//   - MMIO low-byte offsets
//   - RV32 store funct3 codes and a lane-enable helper
package riscv_mem_map_pkg;

    localparam logic [3:0] REGION_DMEM      = 4'b0001;
    localparam logic [3:0] REGION_IMEM      = 4'b0010;
    localparam logic [3:0] REGION_DMEM_IMEM = 4'b0011;
    localparam logic [3:0] REGION_BIOS      = 4'b0100;
    localparam logic [3:0] REGION_IO        = 4'b1000;

    localparam logic [7:0] IO_UART_TX = 8'h08;
    localparam logic [7:0] IO_CNT_RST = 8'h18;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Byte enables for a legal, aligned store; 0 for anything else.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (f3)
            F3_SB: m = 4'b0001 << off;
            F3_SH: if (!off[0]) m = off[1] ? 4'b1100 : 4'b0011;
            F3_SW: if (off == 2'b00) m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_sync_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
//   clk, rst_n            clock, async active-low reset (empties the FIFO)
//   push, push_data       write request; ignored while full
//   rd_data, rd_valid     head entry (0 when empty), non-empty flag
//   rd_ready              consumer accepts head when rd_valid && rd_ready
//   full, count           status
// Full is evaluated before the same-cycle pop, so a full FIFO never accepts
// a push even while it is popping. No write-to-read bypass.
module store_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    import riscv_mem_map_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign do_push  = push && !full;
    assign do_pop   = rd_valid && rd_ready;
    // Gate the head so the output reads 0 after reset without clearing the array.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/store_path_ctrl.sv
// Store-side steering: routes execute-stage stores to DMEM, IMEM or MMIO by
// address region, builds byte enables and lane-replicated write data, and
// buffers UART TX bytes.
//   clk, rst_n                      clock, async active-low reset
//   store_en, addr, wdata, funct3   store request from EX
//   pc_30                           storing instruction runs from BIOS
//   dmem_we/addr/din                DMEM write port (combinational)
//   imem_we/addr/din                IMEM write port (combinational)
//   uart_tx_data/valid/ready        TX FIFO head to the transmitter
//   tx_fifo_full                    IO readback status
//   cnt_rst                         one-cycle counter clear pulse
//   misalign                        one-cycle pulse for a dropped illegal store
//   stall                           hold store in EX (TX FIFO full)
module store_path_ctrl #(
    parameter int DMEM_AW  = 14,
    parameter int IMEM_AW  = 14,
    parameter int TX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               store_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [2:0]         funct3,
    input  logic               pc_30,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    output logic [3:0]         imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready,
    output logic               tx_fifo_full,
    output logic               cnt_rst,
    output logic               misalign,
    output logic               stall
);
    import riscv_mem_map_pkg::*;

    logic [3:0]  region;
    logic [7:0]  io_off;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic        store_ok;
    logic        is_dmem;
    logic        is_imem;
    logic        is_io;
    logic        io_tx_hit;
    logic        io_cnt_hit;
    logic        mem_go;
    logic        tx_push;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic        unused_bits;

    assign region  = addr[31:28];
    assign io_off  = addr[7:0];
    assign lane_we = lane_mask(funct3, addr[1:0]);

    // A zero mask means the funct3/alignment combination is illegal.
    assign store_ok = store_en && (lane_we != 4'b0000);

    always_comb begin
        lane_din = wdata;
        case (funct3)
            F3_SB:   lane_din = {4{wdata[7:0]}};
            F3_SH:   lane_din = {2{wdata[15:0]}};
            default: lane_din = wdata;
        endcase
    end

    assign is_dmem = (region == REGION_DMEM) || (region == REGION_DMEM_IMEM);
    assign is_imem = (region == REGION_IMEM) || (region == REGION_DMEM_IMEM);
    assign is_io   = (region == REGION_IO);

    assign io_tx_hit  = store_ok && is_io && (io_off == IO_UART_TX);
    assign io_cnt_hit = store_ok && is_io && (io_off == IO_CNT_RST);

    // Full is sampled before any same-cycle pop, so the store simply waits.
    assign stall   = io_tx_hit && tx_fifo_full;
    assign tx_push = io_tx_hit && !tx_fifo_full;
    assign mem_go  = store_ok && !stall;

    assign dmem_we   = (mem_go && is_dmem)          ? lane_we : 4'b0000;
    assign imem_we   = (mem_go && is_imem && pc_30) ? lane_we : 4'b0000;
    assign dmem_addr = addr[DMEM_AW+1:2];
    assign imem_addr = addr[IMEM_AW+1:2];
    assign dmem_din  = lane_din;
    assign imem_din  = lane_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rst  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            cnt_rst  <= io_cnt_hit;
            misalign <= store_en && (lane_we == 4'b0000);
        end
    end

    store_sync_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (wdata[7:0]),
        .rd_data   (uart_tx_data),
        .rd_valid  (uart_tx_valid),
        .rd_ready  (uart_tx_ready),
        .full      (tx_fifo_full),
        .count     (tx_count)
    );

    // Address bits above the index fields and the FIFO count are not needed here.
    assign unused_bits = ^{addr, tx_count, REGION_BIOS};

endmodule

// File: tb/tb_store_path_ctrl.sv
module tb_store_path_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        pc_30;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [3:0]  imem_we;
    logic [13:0] imem_addr;
    logic [31:0] imem_din;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic        tx_fifo_full;
    logic        cnt_rst;
    logic        misalign;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_path_ctrl #(.DMEM_AW(14), .IMEM_AW(14), .TX_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .store_en      (store_en),
        .addr          (addr),
        .wdata         (wdata),
        .funct3        (funct3),
        .pc_30         (pc_30),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_din      (dmem_din),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_din      (imem_din),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .tx_fifo_full  (tx_fifo_full),
        .cnt_rst       (cnt_rst),
        .misalign      (misalign),
        .stall         (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic pc);
        store_en = 1'b1;
        funct3   = f3;
        addr     = a;
        wdata    = d;
        pc_30    = pc;
        #1;
    endtask

    task automatic idle();
        store_en = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        funct3   = 3'b000;
        pc_30    = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        uart_tx_ready = 1'b0;
        idle();
        #10;
        chk("rst_valid", uart_tx_valid, 0);
        chk("rst_full", tx_fifo_full, 0);
        chk("rst_cnt_rst", cnt_rst, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // SB to DMEM, top lane
        st(3'b000, 32'h1000_0003, 32'h0000_00AB, 1'b0);
        chk("sb_dmem_we", dmem_we, 4'b1000);
        chk("sb_dmem_din", dmem_din, 32'hABAB_ABAB);
        chk("sb_dmem_addr", dmem_addr, 0);
        chk("sb_imem_we", imem_we, 0);

        // SH upper half
        st(3'b001, 32'h1000_0006, 32'h1234_BEEF, 1'b0);
        chk("sh_dmem_we", dmem_we, 4'b1100);
        chk("sh_dmem_din", dmem_din, 32'hBEEF_BEEF);
        chk("sh_dmem_addr", dmem_addr, 1);

        // SW to DMEM+IMEM from BIOS, then from normal code
        st(3'b010, 32'h3000_0010, 32'h1234_5678, 1'b1);
        chk("sw_both_dmem_we", dmem_we, 4'b1111);
        chk("sw_both_imem_we", imem_we, 4'b1111);
        chk("sw_both_dmem_addr", dmem_addr, 4);
        chk("sw_both_imem_addr", imem_addr, 4);
        chk("sw_both_imem_din", imem_din, 32'h1234_5678);
        st(3'b010, 32'h3000_0010, 32'h1234_5678, 1'b0);
        chk("sw_nobios_imem_we", imem_we, 0);
        chk("sw_nobios_dmem_we", dmem_we, 4'b1111);

        // IMEM-only region
        st(3'b000, 32'h2000_0001, 32'h0000_0077, 1'b1);
        chk("imem_only_imem_we", imem_we, 4'b0010);
        chk("imem_only_dmem_we", dmem_we, 0);
        tick();
        chk("legal_no_misalign", misalign, 0);

        // Misaligned SH: dropped, misalign pulses one cycle
        st(3'b001, 32'h1000_0001, 32'h0000_BEEF, 1'b1);
        chk("mis_dmem_we", dmem_we, 0);
        chk("mis_imem_we", imem_we, 0);
        chk("mis_before_edge", misalign, 0);
        tick();
        idle();
        chk("mis_pulse", misalign, 1);
        tick();
        chk("mis_pulse_end", misalign, 0);

        // Illegal funct3
        st(3'b011, 32'h1000_0000, 32'h1, 1'b1);
        chk("f3_bad_we", dmem_we, 0);
        tick();
        idle();
        chk("f3_bad_misalign", misalign, 1);
        tick();

        // BIOS region write is silently dropped
        st(3'b010, 32'h4000_0000, 32'hDEAD_BEEF, 1'b1);
        chk("bios_dmem_we", dmem_we, 0);
        chk("bios_imem_we", imem_we, 0);
        tick();
        idle();
        chk("bios_no_misalign", misalign, 0);

        // Five UART pushes with transmitter not ready
        uart_tx_ready = 1'b0;
        chk("tx_empty_valid", uart_tx_valid, 0);
        st(3'b000, 32'h8000_0008, 32'h11, 1'b0);
        chk("tx_push1_stall", stall, 0);
        chk("tx_io_dmem_we", dmem_we, 0);
        tick();
        chk("tx_valid_after_push", uart_tx_valid, 1);
        chk("tx_head_after_push", uart_tx_data, 8'h11);
        st(3'b000, 32'h8000_0008, 32'h22, 1'b0);
        chk("tx_push2_stall", stall, 0);
        tick();
        st(3'b000, 32'h8000_0008, 32'h33, 1'b0);
        chk("tx_push3_stall", stall, 0);
        tick();
        st(3'b000, 32'h8000_0008, 32'h44, 1'b0);
        chk("tx_push4_full_pre", tx_fifo_full, 0);
        tick();
        chk("tx_full_after4", tx_fifo_full, 1);
        st(3'b000, 32'h8000_0008, 32'h55, 1'b0);
        chk("tx_push5_stall", stall, 1);
        tick();
        chk("tx_still_full", tx_fifo_full, 1);
        idle();
        chk("tx_stall_clear", stall, 0);

        // Drain in order
        uart_tx_ready = 1'b1;
        #1;
        chk("drain0", uart_tx_data, 8'h11);
        tick();
        chk("drain1", uart_tx_data, 8'h22);
        chk("drain1_full", tx_fifo_full, 0);
        tick();
        chk("drain2", uart_tx_data, 8'h33);
        tick();
        chk("drain3", uart_tx_data, 8'h44);
        chk("drain3_valid", uart_tx_valid, 1);
        tick();
        chk("drain_done_valid", uart_tx_valid, 0);
        chk("drain_done_data", uart_tx_data, 0);

        // Counter reset pulse
        st(3'b010, 32'h8000_0018, 32'h0, 1'b0);
        chk("cnt_rst_pre", cnt_rst, 0);
        tick();
        idle();
        chk("cnt_rst_pulse", cnt_rst, 1);
        tick();
        chk("cnt_rst_end", cnt_rst, 0);

        // Other IO offset: ignored, no misalign
        st(3'b010, 32'h8000_0020, 32'h0, 1'b0);
        chk("io_other_stall", stall, 0);
        tick();
        idle();
        chk("io_other_misalign", misalign, 0);
        chk("io_other_valid", uart_tx_valid, 0);

        // Full FIFO with simultaneous push and pop
        uart_tx_ready = 1'b0;
        st(3'b000, 32'h8000_0008, 32'hA1, 1'b0); tick();
        st(3'b000, 32'h8000_0008, 32'hA2, 1'b0); tick();
        st(3'b000, 32'h8000_0008, 32'hA3, 1'b0); tick();
        st(3'b000, 32'h8000_0008, 32'hA4, 1'b0); tick();
        chk("pp_full", tx_fifo_full, 1);
        st(3'b000, 32'h8000_0008, 32'hA5, 1'b0);
        uart_tx_ready = 1'b1;
        #1;
        chk("pp_stall_while_pop", stall, 1);
        tick();
        chk("pp_full_after_pop", tx_fifo_full, 0);
        chk("pp_head_a2", uart_tx_data, 8'hA2);
        chk("pp_stall_released", stall, 0);
        tick();
        chk("pp_head_a3", uart_tx_data, 8'hA3);
        chk("pp_not_full", tx_fifo_full, 0);
        idle();
        tick();
        chk("pp_head_a4", uart_tx_data, 8'hA4);

        // Async reset mid-drain
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", uart_tx_valid, 0);
        chk("mid_rst_data", uart_tx_data, 0);
        chk("mid_rst_full", tx_fifo_full, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", uart_tx_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
